// File: rtl/pipe_adder_pkg.sv
// Shared defaults and mode encodings for the pipelined chunked adder.
package pipe_adder_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int STAGES_DEF = 2;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/pipe_adder_stage.sv
// One CHUNK-bit slice of the carry chain: unsigned add with carry in and out.
module pipe_adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder: each stage adds one CHUNK-bit slice; remaining operand bits
// and finished sum bits ride along in skew registers, shifted one chunk per stage.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_en;

  logic [WIDTH-1:0] w_a_src   [STAGES];
  logic [WIDTH-1:0] w_b_src   [STAGES];
  logic [WIDTH-1:0] w_sum_src [STAGES];
  logic             w_c_src   [STAGES];
  logic             w_vld_src [STAGES];
  logic             w_sat_src [STAGES];

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];
  logic             r_sat [STAGES];
  logic             r_vld [STAGES];

  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;

  // Sum bits enter at the top and shift down, so after STAGES steps chunk 0 sits at bit 0.
  function automatic logic [WIDTH-1:0] insert_chunk(input logic [WIDTH-1:0] acc,
                                                    input logic [CHUNK-1:0] s);
    logic [WIDTH-1:0] t;
    t = acc >> CHUNK;
    t[WIDTH-CHUNK +: CHUNK] = s;
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                input logic             carry,
                                                input logic             mode);
    return ((mode == MODE_SAT) && carry) ? '1 : sum;
  endfunction

  assign w_en      = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;

    if (k == 0) begin : g_src_in
      assign w_a_src[k]   = in_a;
      assign w_b_src[k]   = in_b;
      assign w_sum_src[k] = '0;
      assign w_c_src[k]   = in_cin;
      assign w_vld_src[k] = in_valid;
      assign w_sat_src[k] = in_sat;
    end else begin : g_src_reg
      assign w_a_src[k]   = r_a[k-1];
      assign w_b_src[k]   = r_b[k-1];
      assign w_sum_src[k] = r_sum[k-1];
      assign w_c_src[k]   = r_c[k-1];
      assign w_vld_src[k] = r_vld[k-1];
      assign w_sat_src[k] = r_sat[k-1];
    end

    pipe_adder_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .i_a    (w_a_src[k][CHUNK-1:0]),
      .i_b    (w_b_src[k][CHUNK-1:0]),
      .i_cin  (w_c_src[k]),
      .o_sum  (w_s),
      .o_cout (w_co)
    );

    assign w_sum_next = insert_chunk(w_sum_src[k], w_s);

    // Stage boundary k: valid bits clear asynchronously; bubbles advance like data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld[k] <= 1'b0;
      end else if (w_en) begin
        r_vld[k] <= w_vld_src[k];
      end
    end

    if (k == STAGES-1) begin : g_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_sum  <= '0;
          r_out_cout <= 1'b0;
        end else if (w_en) begin
          r_out_sum  <= saturate(w_sum_next, w_co, w_sat_src[k]);
          r_out_cout <= w_co;
        end
      end
    end else begin : g_skew
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_a[k]   <= w_a_src[k] >> CHUNK;
          r_b[k]   <= w_b_src[k] >> CHUNK;
          r_sum[k] <= w_sum_next;
          r_c[k]   <= w_co;
          r_sat[k] <= w_sat_src[k];
        end
      end
    end
  end

endmodule
